// File: rtl/alu_pipe_unit.sv
// -----------------------------------------------------------------------------
// alu_pipe_unit
//
// Pipelined integer ALU execution unit for the out-of-order core. Tagged ops
// from the reservation station are evaluated at dispatch. The result then
// travels with its tag through LATENCY stage registers into a circular output
// queue. The queue head is offered to the CDB arbiter under valid/ack.
//
// A credit counter covers in-flight and queued ops. It is bounded by
// OUT_DEPTH, so the output queue can never overflow. A flush or reset drops
// every in-flight and queued op.
//
// Build option:
//   ALU_SHIFT_EN  defined   -> opcodes 2/3/7 perform SLL/SRL/SRA.
//                 undefined -> no barrel shifter; opcodes 2/3/7 produce 0.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             discard all in-flight and queued ops
//   dispatch_valid    op offered by the reservation station
//   dispatch_op       4-bit opcode
//   dispatch_val1/2   operands A/B (DATA_WIDTH)
//   dispatch_tag      destination tag (TAG_WIDTH)
//   dispatch_ack      op accepted this cycle (combinational, depends on result_ack)
//   result_valid      output queue head valid
//   result_tag/data   output queue head contents (zero when not valid)
//   result_ack        CDB consumed the head this cycle
//   busy              any op in flight or queued
// -----------------------------------------------------------------------------
module alu_pipe_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 6,
    parameter int LATENCY    = 1,
    parameter int OUT_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  dispatch_valid,
    input  logic [3:0]            dispatch_op,
    input  logic [DATA_WIDTH-1:0] dispatch_val1,
    input  logic [DATA_WIDTH-1:0] dispatch_val2,
    input  logic [TAG_WIDTH-1:0]  dispatch_tag,
    output logic                  dispatch_ack,
    output logic                  result_valid,
    output logic [TAG_WIDTH-1:0]  result_tag,
    output logic [DATA_WIDTH-1:0] result_data,
    input  logic                  result_ack,
    output logic                  busy
);

    localparam int SH_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SRL  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9
    } alu_op_e;

    // Combinational ALU evaluated at dispatch.
    function automatic logic [DATA_WIDTH-1:0] alu_compute(
        input logic [3:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic signed [DATA_WIDTH-1:0] sa;
        logic signed [DATA_WIDTH-1:0] sb;
        logic        [DATA_WIDTH-1:0] res;
`ifdef ALU_SHIFT_EN
        logic        [SH_W-1:0]       shamt;
        shamt = b[SH_W-1:0];  // upper shift-amount bits are ignored
`endif
        sa  = a;
        sb  = b;
        res = '0;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_SLT:  res = DATA_WIDTH'(sa < sb);
            OP_SLTU: res = DATA_WIDTH'(a < b);
`ifdef ALU_SHIFT_EN
            OP_SLL:  res = a << shamt;
            OP_SRL:  res = a >> shamt;
            OP_SRA:  res = sa >>> shamt;
`endif
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        // Explicit wrap so OUT_DEPTH need not be a power of two.
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pipeline stage registers
    logic                  stg_vld_q  [LATENCY];
    logic                  stg_vld_d  [LATENCY];
    logic [TAG_WIDTH-1:0]  stg_tag_q  [LATENCY];
    logic [TAG_WIDTH-1:0]  stg_tag_d  [LATENCY];
    logic [DATA_WIDTH-1:0] stg_data_q [LATENCY];
    logic [DATA_WIDTH-1:0] stg_data_d [LATENCY];

    // Output queue storage and control
    logic [TAG_WIDTH-1:0]  q_tag_mem  [OUT_DEPTH];
    logic [DATA_WIDTH-1:0] q_data_mem [OUT_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      q_cnt_q,  q_cnt_d;
    logic [CNT_W-1:0]      count_q,  count_d;

    logic accept;
    logic push;
    logic pop;
    logic q_full;

    // Handshake
    always_comb begin
        result_valid = !rst && (q_cnt_q != '0);
        result_tag   = result_valid ? q_tag_mem[rd_ptr_q]  : '0;
        result_data  = result_valid ? q_data_mem[rd_ptr_q] : '0;
        busy         = !rst && (count_q != '0);
        // An ack during flush is ignored, so it frees no credit.
        pop          = result_valid && result_ack && !flush;
        dispatch_ack = dispatch_valid && !flush && !rst &&
                       ((count_q < CNT_W'(OUT_DEPTH)) || (result_valid && result_ack));
        accept       = dispatch_ack;
        push         = stg_vld_q[LATENCY-1] && !flush;
        q_full       = (q_cnt_q == CNT_W'(OUT_DEPTH));
    end

    // Stage 0 captures the dispatched op; later stages shift forward
    always_comb begin
        stg_vld_d[0]  = accept;
        stg_tag_d[0]  = dispatch_tag;
        stg_data_d[0] = alu_compute(dispatch_op, dispatch_val1, dispatch_val2);
        for (int i = 1; i < LATENCY; i++) begin
            stg_vld_d[i]  = stg_vld_q[i-1] && !flush;
            stg_tag_d[i]  = stg_tag_q[i-1];
            stg_data_d[i] = stg_data_q[i-1];
        end
    end

    // Queue pointers and credit counter
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        q_cnt_d  = q_cnt_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            q_cnt_d  = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_next(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_next(rd_ptr_q);
            q_cnt_d = q_cnt_q + CNT_W'(push) - CNT_W'(pop);
            count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
        end
    end

    // Control state: reset applies here only
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) stg_vld_q[i] <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            q_cnt_q  <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < LATENCY; i++) stg_vld_q[i] <= stg_vld_d[i];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            q_cnt_q  <= q_cnt_d;
            count_q  <= count_d;
        end
    end

    // Data path: payload is qualified by the valids above, so no reset needed
    always_ff @(posedge clk) begin
        for (int i = 0; i < LATENCY; i++) begin
            stg_tag_q[i]  <= stg_tag_d[i];
            stg_data_q[i] <= stg_data_d[i];
        end
        if (push) begin
            q_tag_mem[wr_ptr_q]  <= stg_tag_q[LATENCY-1];
            q_data_mem[wr_ptr_q] <= stg_data_q[LATENCY-1];
        end
    end

    // The credit limit makes a write into a full queue impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && q_full));

endmodule

// File: tb/tb_alu_pipe_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe_unit
//
// Three instances of alu_pipe_unit: (LATENCY,OUT_DEPTH) = (1,2), (2,3), (3,4).
// One instance is exercised at a time (sel). A negedge monitor pushes the
// expected {tag,result} on every accepted dispatch and pops/compares on every
// consumed result. Expected shift results depend on ALU_SHIFT_EN.
// -----------------------------------------------------------------------------
module tb_alu_pipe_unit;

    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] data;
    } sb_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [3];
    logic        flush [3];
    logic        dv    [3];
    logic [3:0]  dop   [3];
    logic [31:0] da    [3];
    logic [31:0] db    [3];
    logic [5:0]  dtag  [3];
    logic        rack  [3];
    wire  [2:0]  dack;
    wire  [2:0]  rv;
    wire  [2:0]  busy;
    wire  [5:0]  rtag  [3];
    wire  [31:0] rdata [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        alu_pipe_unit #(
            .DATA_WIDTH(32),
            .TAG_WIDTH (6),
            .LATENCY   (g + 1),
            .OUT_DEPTH (g + 2)
        ) u_dut (
            .clk           (clk),
            .rst           (rst[g]),
            .flush         (flush[g]),
            .dispatch_valid(dv[g]),
            .dispatch_op   (dop[g]),
            .dispatch_val1 (da[g]),
            .dispatch_val2 (db[g]),
            .dispatch_tag  (dtag[g]),
            .dispatch_ack  (dack[g]),
            .result_valid  (rv[g]),
            .result_tag    (rtag[g]),
            .result_data   (rdata[g]),
            .result_ack    (rack[g]),
            .busy          (busy[g])
        );
    end

    int  n_cmp = 0;
    int  n_err = 0;
    int  sel   = 0;
    sb_t sbq[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (time %0t)", tag, got, exp, $time);
        end
    endtask

    // Reference ALU
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            4'd0: return a + b;
            4'd1: return a + ~b + 32'd1;
            4'd4: return a & b;
            4'd5: return a | b;
            4'd6: return a ^ b;
            4'd8: return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
            4'd9: return {31'd0, (a < b)};
`ifdef ALU_SHIFT_EN
            4'd2: return a << sh;
            4'd3: return a >> sh;
            4'd7: return (a >> sh) | ((sh == 5'd0) ? 32'd0 : ({32{a[31]}} << (6'd32 - {1'b0, sh})));
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        sb_t e;
        if (rst[sel] || flush[sel]) begin
            sbq.delete();
        end else begin
            if (rv[sel] && rack[sel]) begin
                if (sbq.size() == 0) begin
                    check_val("sb_unexpected_result", 64'(sbq.size()), 64'd1);
                end else begin
                    e = sbq.pop_front();
                    check_val("res_tag", 64'(rtag[sel]), 64'(e.tag));
                    check_val("res_data", 64'(rdata[sel]), 64'(e.data));
                end
            end
            if (dack[sel]) sbq.push_back({dtag[sel], ref_alu(dop[sel], da[sel], db[sel])});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one op and hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] tag);
        int w;
        dv[sel] = 1'b1; dop[sel] = op; da[sel] = a; db[sel] = b; dtag[sel] = tag;
        w = 0;
        @(negedge clk);
        while (!dack[sel] && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!dack[sel]) check_val("send_timeout", 64'(dack[sel]), 64'd1);
        step();
    endtask

    task automatic drain();
        int w;
        dv[sel] = 1'b0;
        rack[sel] = 1'b1;
        w = 0;
        @(negedge clk);
        while (busy[sel] && w < 60) begin
            @(negedge clk);
            w++;
        end
        check_val("drain_busy", 64'(busy[sel]), 64'd0);
        step();
        rack[sel] = 1'b0;
        check_val("sb_left", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, rvcnt, run, maxrun;
        for (int g = 0; g < 3; g++) begin
            rst[g] = 1'b1; flush[g] = 1'b0; dv[g] = 1'b1; dop[g] = 4'd0;
            da[g] = 32'd1; db[g] = 32'd2; dtag[g] = 6'd1; rack[g] = 1'b0;
        end

        // ---------------- reset values ----------------
        repeat (3) step();
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check_val("rst_result_valid", 64'(rv[g]), 64'd0);
            check_val("rst_result_tag", 64'(rtag[g]), 64'd0);
            check_val("rst_result_data", 64'(rdata[g]), 64'd0);
            check_val("rst_busy", 64'(busy[g]), 64'd0);
            check_val("rst_dispatch_ack", 64'(dack[g]), 64'd0);
        end
        step();
        for (int g = 0; g < 3; g++) begin
            rst[g] = 1'b0; dv[g] = 1'b0;
        end
        repeat (2) step();

        // ---------------- latency, LATENCY=1 ----------------
        sel = 0;
        dv[0] = 1'b1; dop[0] = 4'd0; da[0] = 32'd5; db[0] = 32'd7; dtag[0] = 6'd3;
        @(negedge clk);
        check_val("lat_accept", 64'(dack[0]), 64'd1);
        step();
        dv[0] = 1'b0;
        @(negedge clk);
        check_val("lat_c1_valid", 64'(rv[0]), 64'd0);
        check_val("lat_c1_busy", 64'(busy[0]), 64'd1);
        step();
        @(negedge clk);
        check_val("lat_c2_valid", 64'(rv[0]), 64'd1);
        check_val("lat_c2_tag", 64'(rtag[0]), 64'd3);
        check_val("lat_c2_data", 64'(rdata[0]), 64'd12);
        for (int k = 0; k < 2; k++) begin
            step();
            @(negedge clk);
            check_val("lat_hold_valid", 64'(rv[0]), 64'd1);
            check_val("lat_hold_data", 64'(rdata[0]), 64'd12);
        end
        step();
        rack[0] = 1'b1;
        step();
        rack[0] = 1'b0;
        @(negedge clk);
        check_val("lat_after_ack_valid", 64'(rv[0]), 64'd0);
        check_val("lat_after_ack_busy", 64'(busy[0]), 64'd0);
        step();

        // ---------------- opcode coverage ----------------
        rack[0] = 1'b1;
        send(4'd1, 32'h0000_0000, 32'h0000_0001, 6'd1);   // SUB wraps
        send(4'd8, 32'hFFFF_FFFF, 32'h0000_0001, 6'd2);   // SLT -> 1
        send(4'd9, 32'hFFFF_FFFF, 32'h0000_0001, 6'd3);   // SLTU -> 0
        send(4'd7, 32'h8000_0000, 32'h0000_0004, 6'd4);   // SRA
        send(4'd2, 32'h0000_0001, 32'd33, 6'd5);          // SLL by 33 -> by 1
        send(4'd3, 32'h8000_0000, 32'd35, 6'd6);          // SRL by 35 -> by 3
        send(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 6'd7);   // ADD wraps
        send(4'd4, 32'hF0F0_1234, 32'h0FF0_FF00, 6'd8);
        send(4'd5, 32'hF0F0_1234, 32'h0FF0_FF00, 6'd9);
        send(4'd6, 32'hF0F0_1234, 32'h0FF0_FF00, 6'd10);
        send(4'd8, 32'h0000_0005, 32'h8000_0000, 6'd11);  // SLT positive vs negative -> 0
        send(4'd12, 32'h1234_5678, 32'h1111_1111, 6'd12); // undefined -> 0
        send(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd13);
        drain();

        // ---------------- back-pressure, LATENCY=2 OUT_DEPTH=3 ----------------
        sel = 1;
        rack[1] = 1'b0;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            dv[1] = 1'b1; dop[1] = 4'd0; da[1] = 32'(20 + acc); db[1] = 32'd100;
            dtag[1] = 6'(20 + acc);
            @(negedge clk);
            if (dack[1]) acc++;
            step();
        end
        check_val("bp_accepts", 64'(acc), 64'd3);
        dtag[1] = 6'(20 + acc); da[1] = 32'(20 + acc);
        @(negedge clk);
        check_val("bp_stalled_ack", 64'(dack[1]), 64'd0);
        check_val("bp_busy", 64'(busy[1]), 64'd1);
        step();
        rack[1] = 1'b1;   // pop and accept in the same cycle at count == OUT_DEPTH
        @(negedge clk);
        check_val("bp_pop_accept", 64'(dack[1]), 64'd1);
        if (dack[1]) acc++;
        step();
        rack[1] = 1'b0;
        dtag[1] = 6'(20 + acc); da[1] = 32'(20 + acc);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (dack[1]) acc++;
            step();
        end
        check_val("bp_one_more_accept", 64'(acc), 64'd4);
        @(negedge clk);
        check_val("bp_busy_after", 64'(busy[1]), 64'd1);
        step();
        drain();

        // ---------------- full throughput, LATENCY=3 OUT_DEPTH=4 ----------------
        sel = 2;
        rack[2] = 1'b1;
        acc = 0; rvcnt = 0; run = 0; maxrun = 0;
        for (int k = 0; k < 40; k++) begin
            if (k < 20) begin
                dv[2] = 1'b1; dop[2] = 4'(k % 10); da[2] = $urandom; db[2] = $urandom;
                dtag[2] = 6'(k);
            end else begin
                dv[2] = 1'b0;
            end
            @(negedge clk);
            if (k < 20 && dack[2]) acc++;
            if (rv[2]) begin
                rvcnt++;
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            step();
        end
        check_val("tp_accepts", 64'(acc), 64'd20);
        check_val("tp_results", 64'(rvcnt), 64'd20);
        check_val("tp_consecutive", 64'(maxrun), 64'd20);
        check_val("tp_busy_end", 64'(busy[2]), 64'd0);
        rack[2] = 1'b0;

        // ---------------- flush: 3 in flight + 1 queued ----------------
        send(4'd0, 32'd1, 32'd1, 6'd40);
        send(4'd0, 32'd2, 32'd2, 6'd41);
        send(4'd0, 32'd3, 32'd3, 6'd42);
        send(4'd0, 32'd4, 32'd4, 6'd43);
        flush[2] = 1'b1; rack[2] = 1'b1;
        dv[2] = 1'b1; dop[2] = 4'd0; da[2] = 32'd9; db[2] = 32'd9; dtag[2] = 6'd50;
        @(negedge clk);
        check_val("fl_head_valid", 64'(rv[2]), 64'd1);
        check_val("fl_head_tag", 64'(rtag[2]), 64'd40);
        check_val("fl_ack_blocked", 64'(dack[2]), 64'd0);
        step();
        flush[2] = 1'b0; rack[2] = 1'b0;
        dop[2] = 4'd6; da[2] = 32'hDEAD_BEEF; db[2] = 32'h0F0F_0F0F; dtag[2] = 6'd51;
        @(negedge clk);
        check_val("fl_next_valid", 64'(rv[2]), 64'd0);
        check_val("fl_next_busy", 64'(busy[2]), 64'd0);
        check_val("fl_next_accept", 64'(dack[2]), 64'd1);
        step();
        dv[2] = 1'b0;
        drain();

        // ---------------- reset mid-stream ----------------
        sel = 1;
        rack[1] = 1'b0;
        send(4'd0, 32'd11, 32'd22, 6'd60);
        send(4'd1, 32'd50, 32'd8, 6'd61);
        rst[1] = 1'b1; dv[1] = 1'b1;
        @(negedge clk);
        check_val("mrst_ack", 64'(dack[1]), 64'd0);
        step();
        rst[1] = 1'b0; dv[1] = 1'b0;
        @(negedge clk);
        check_val("mrst_valid", 64'(rv[1]), 64'd0);
        check_val("mrst_tag", 64'(rtag[1]), 64'd0);
        check_val("mrst_data", 64'(rdata[1]), 64'd0);
        check_val("mrst_busy", 64'(busy[1]), 64'd0);
        repeat (4) step();
        @(negedge clk);
        check_val("mrst_still_empty", 64'(rv[1]), 64'd0);
        check_val("mrst_sb_empty", 64'(sbq.size()), 64'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
